cordic_scheduler: RTL and testbench
===================================

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one cordic core.
REQ-002 Parameter W, default 32, angle/result width; angles signed Q3.29 radians.
REQ-003 Parameter CORE_LAT, default 32, cycles from core angle sample to valid sin/cos.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  N_REQ  per-requester angle request.
REQ-007 req_angle  input  N_REQ*W  per-requester signed angle, requester i at bits [i*W +: W].
REQ-008 req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-009 core_angle  output  W  registered angle to cordic core.
REQ-010 core_sin, core_cos  input  W each  cordic core results.
REQ-011 res_valid  output  N_REQ  one-hot, one-cycle result strobe to owning requester.
REQ-012 res_sin, res_cos  output  W each  shared result bus, valid only with res_valid.
REQ-013 inflight  output  $clog2(CORE_LAT+3)  count of accepted, not yet delivered requests.

Function
REQ-014 Arbitration SHALL be round-robin: at most one grant per cycle; search starts at requester after last granted; no valid request -> no grant, pointer unchanged.
REQ-015 req_ready SHALL be combinational from req_valid and pointer; ready never asserted to a requester with req_valid=0.
REQ-016 No backpressure from results: a grant SHALL be issued every cycle a request is pending (full throughput, one per cycle).
REQ-017 Range fold on accepted angle a: a > HALF_PI -> core angle a-PI, flip=1; a < -HALF_PI -> a+PI, flip=1; else a, flip=0; a = +/-HALF_PI exactly not folded.
REQ-018 Fold arithmetic SHALL be W-bit two's complement; results stay within [-HALF_PI, HALF_PI], no overflow for any input in [-PI, PI).
REQ-019 Accept at edge T -> core_angle updated at edge T+1; idle cycles drive core_angle to 0.
REQ-020 A tag delay line of CORE_LAT+1 stages SHALL carry {valid, requester index, flip} alongside each core sample.
REQ-021 Result for acceptance at edge T SHALL be registered on res_* at edge T+CORE_LAT+2 (fixed latency CORE_LAT+2 cycles).
REQ-022 flip=1 -> res_sin = -core_sin, res_cos = -core_cos (two's complement negate); flip=0 -> pass-through.
REQ-023 res_sin/res_cos SHALL hold previous values when res_valid=0.
REQ-024 inflight increments on acceptance, decrements on res_valid, unchanged when both occur same cycle.
REQ-025 Results SHALL be delivered in acceptance order; back-to-back requests from one requester yield consecutive strobes.

Reset
REQ-026 rst_n low SHALL asynchronously clear: rr pointer to requester 0, all tag valids, core_angle, res_valid, res_sin, res_cos, inflight to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight requests; no res_valid for them after release.
REQ-028 req_ready SHALL be 0 while rst_n is low.

Structure
REQ-029 Shared package cordic_pkg SHALL hold W, Q3.29 constants PI = 32'h6487ED51 and HALF_PI = 32'h3243F6A8, CORE_LAT default, tag record typedef {valid, idx, flip}.
REQ-030 Round-robin arbiter SHALL be sub-module rr_arbiter (N_REQ parameter, valid in, one-hot grant out, pointer state).
REQ-031 cordic core SHALL be instantiated outside this block; bench uses a behavioural core model with exactly CORE_LAT latency.

Verification
REQ-032 Single request i=0, angle 32'h1015BF99 -> res_valid[0] exactly CORE_LAT+2 cycles later, sin/cos equal model, inflight 1 then 0.
REQ-033 All 4 requesters valid continuously 8 cycles -> grants 0,1,2,3,0,1,2,3; results in same order on consecutive cycles.
REQ-034 Angle 32'h6285358C (> HALF_PI) -> core_angle = 32'hFDFD483B, results negated vs core output.
REQ-035 Angles 32'h3243F6A8 and 32'hCDBC0958 -> no fold, flip=0; angle 32'h9B7812AF (-PI) -> core_angle 0, flip=1.
REQ-036 Assert rst_n low with 10 requests in flight -> outputs zero immediately, no res_valid after release, inflight 0.
REQ-037 Accept and deliver in same cycle -> inflight unchanged; sparse random traffic -> inflight never exceeds CORE_LAT+2.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg -- shared constants and tag record for the CORDIC scheduler
// rev 1.0
`timescale 1ns/1ps
`default_nettype none
package cordic_pkg;
  localparam int W        = 32;
  localparam int CORE_LAT = 32;

  // Q3.29 radians
  localparam logic [31:0] PI      = 32'h6487ED51;
  localparam logic [31:0] HALF_PI = 32'h3243F6A8;

  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic                 flip;
  } tag_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter -- one-hot round-robin arbiter, search starts after the last grant
// rev 1.0
`timescale 1ns/1ps
`default_nettype none
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_any
);
  logic [IW-1:0] ptr_q, ptr_d;

  // ptr_q holds the first candidate index, i.e. one past the last grant
  always_comb begin
    int            c;
    logic [IW-1:0] cand;
    c         = 0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      c = int'(ptr_q) + off;
      if (c >= N_REQ) c = c - N_REQ;
      cand = IW'(c);
      if (!grant_any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (grant_any) ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule
`default_nettype wire

// File: rtl/cordic_scheduler.sv
// cordic_scheduler -- shares one CORDIC core among N_REQ requesters with range fold
// rev 1.0
`timescale 1ns/1ps
`default_nettype none
module cordic_scheduler #(
  parameter int N_REQ    = 4,
  parameter int W        = cordic_pkg::W,
  parameter int CORE_LAT = cordic_pkg::CORE_LAT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*W-1:0]             req_angle,
  output logic [N_REQ-1:0]               req_ready,
  output logic [W-1:0]                   core_angle,
  input  logic [W-1:0]                   core_sin,
  input  logic [W-1:0]                   core_cos,
  output logic [N_REQ-1:0]               res_valid,
  output logic [W-1:0]                   res_sin,
  output logic [W-1:0]                   res_cos,
  output logic [$clog2(CORE_LAT+3)-1:0]  inflight
);
  import cordic_pkg::*;

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IF_W = $clog2(CORE_LAT + 3);

  // Top-align the Q3.29 constants so they keep three integer bits at any W
  localparam logic [63:0]         PI_X          = {PI, 32'h0};
  localparam logic [63:0]         HALF_PI_X     = {HALF_PI, 32'h0};
  localparam logic signed [W-1:0] PI_W          = PI_X[63 -: W];
  localparam logic signed [W-1:0] HALF_PI_W     = HALF_PI_X[63 -: W];
  localparam logic signed [W-1:0] NEG_HALF_PI_W = -HALF_PI_W;

  logic [N_REQ-1:0]    grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_any;
  logic                accept;
  logic signed [W-1:0] sel_angle;
  logic signed [W-1:0] fold_angle;
  logic                fold_flip;

  tag_t                acc_tag_q, acc_tag_d;
  logic [W-1:0]        acc_angle_q, acc_angle_d;
  logic [W-1:0]        core_angle_q, core_angle_d;
  tag_t                tag_q [CORE_LAT+1];
  tag_t                tag_d [CORE_LAT+1];
  tag_t                out_tag;
  logic [N_REQ-1:0]    res_valid_q, res_valid_d;
  logic [W-1:0]        res_sin_q, res_sin_d;
  logic [W-1:0]        res_cos_q, res_cos_d;
  logic [IF_W-1:0]     inflight_q, inflight_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = rst_n ? grant : '0;
  assign accept    = grant_any & rst_n;

  always_comb begin
    sel_angle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_angle = req_angle[i*W +: W];
    end
    fold_angle = sel_angle;
    fold_flip  = 1'b0;
    if (sel_angle > HALF_PI_W) begin
      fold_angle = sel_angle - PI_W;
      fold_flip  = 1'b1;
    end else if (sel_angle < NEG_HALF_PI_W) begin
      fold_angle = sel_angle + PI_W;
      fold_flip  = 1'b1;
    end
  end

  always_comb begin
    acc_tag_d       = '0;
    acc_tag_d.valid = accept;
    acc_tag_d.idx   = TAG_IDX_W'(grant_idx);
    acc_tag_d.flip  = fold_flip;
    acc_angle_d     = accept ? fold_angle : acc_angle_q;
    core_angle_d    = acc_tag_q.valid ? acc_angle_q : '0;

    // Tag line runs beside the core so the tag at the tail matches core_sin/cos
    tag_d[0] = acc_tag_q;
    for (int i = 1; i <= CORE_LAT; i++) tag_d[i] = tag_q[i-1];
    out_tag = tag_q[CORE_LAT];

    res_valid_d = '0;
    res_sin_d   = res_sin_q;
    res_cos_d   = res_cos_q;
    if (out_tag.valid) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (out_tag.idx == TAG_IDX_W'(i)) res_valid_d[i] = 1'b1;
      end
      res_sin_d = out_tag.flip ? -core_sin : core_sin;
      res_cos_d = out_tag.flip ? -core_cos : core_cos;
    end

    inflight_d = inflight_q + IF_W'(accept) - IF_W'(out_tag.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_tag_q    <= '0;
      acc_angle_q  <= '0;
      core_angle_q <= '0;
      for (int i = 0; i <= CORE_LAT; i++) tag_q[i] <= '0;
      res_valid_q  <= '0;
      res_sin_q    <= '0;
      res_cos_q    <= '0;
      inflight_q   <= '0;
    end else begin
      acc_tag_q    <= acc_tag_d;
      acc_angle_q  <= acc_angle_d;
      core_angle_q <= core_angle_d;
      for (int i = 0; i <= CORE_LAT; i++) tag_q[i] <= tag_d[i];
      res_valid_q  <= res_valid_d;
      res_sin_q    <= res_sin_d;
      res_cos_q    <= res_cos_d;
      inflight_q   <= inflight_d;
    end
  end

  assign core_angle = core_angle_q;
  assign res_valid  = res_valid_q;
  assign res_sin    = res_sin_q;
  assign res_cos    = res_cos_q;
  assign inflight   = inflight_q;
endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler -- directed and sparse-random scoreboard bench
// rev 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_cordic_scheduler;
  localparam int N_REQ    = 4;
  localparam int W        = 32;
  localparam int CORE_LAT = 32;
  localparam int IF_W     = $clog2(CORE_LAT + 3);
  localparam logic [31:0] PI_C   = 32'h6487ED51;
  localparam logic [31:0] HALF_C = 32'h3243F6A8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*W-1:0]   req_angle;
  logic [N_REQ-1:0]     req_ready;
  logic [W-1:0]         core_angle, core_sin, core_cos;
  logic [N_REQ-1:0]     res_valid;
  logic [W-1:0]         res_sin, res_cos;
  logic [IF_W-1:0]      inflight;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_inflight = 0;

  typedef struct {
    int          idx;
    logic [31:0] s;
    logic [31:0] c;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_scheduler #(
    .N_REQ    (N_REQ),
    .W        (W),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .core_angle (core_angle),
    .core_sin   (core_sin),
    .core_cos   (core_cos),
    .res_valid  (res_valid),
    .res_sin    (res_sin),
    .res_cos    (res_cos),
    .inflight   (inflight)
  );

  function automatic logic [31:0] f_sin(input logic [31:0] a);
    return a * 32'd3 + 32'd17;
  endfunction

  function automatic logic [31:0] f_cos(input logic [31:0] a);
    return a ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [32:0] fold(input logic [31:0] a);
    if ($signed(a) > $signed(HALF_C))  return {1'b1, a - PI_C};
    if ($signed(a) < -$signed(HALF_C)) return {1'b1, a + PI_C};
    return {1'b0, a};
  endfunction

  // Behavioural core: exactly CORE_LAT register stages after core_angle
  logic [W-1:0] core_pipe [CORE_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_angle;
    for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_sin = f_sin(core_pipe[CORE_LAT-1]);
  assign core_cos = f_cos(core_pipe[CORE_LAT-1]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on each transfer, pop on each result strobe
  exp_t        mon_e;
  logic [32:0] mon_fr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid != '0) begin
        model_inflight--;
        if (sb.size() == 0) begin
          check("unexpected_res", {60'd0, res_valid}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("res_onehot", {60'd0, res_valid}, 64'd1 << mon_e.idx);
          check("res_sin", {32'd0, res_sin}, {32'd0, mon_e.s});
          check("res_cos", {32'd0, res_cos}, {32'd0, mon_e.c});
          check("res_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("res_missing", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
      check("inflight", {58'd0, inflight}, 64'(model_inflight));
      check("inflight_max", {63'd0, (int'(inflight) <= CORE_LAT + 2)}, 64'd1);
      check("ready_no_valid", {60'd0, req_ready & ~req_valid}, 64'd0);
      check("ready_onehot", {63'd0, ($countones(req_ready) <= 1)}, 64'd1);
      check("ready_throughput", {63'd0, (req_ready != '0)}, {63'd0, (req_valid != '0)});
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_fr    = fold(req_angle[i*W +: W]);
          mon_e.idx = i;
          mon_e.s   = mon_fr[32] ? -f_sin(mon_fr[31:0]) : f_sin(mon_fr[31:0]);
          mon_e.c   = mon_fr[32] ? -f_cos(mon_fr[31:0]) : f_cos(mon_fr[31:0]);
          mon_e.due = cyc + CORE_LAT + 3;
          sb.push_back(mon_e);
          model_inflight++;
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < CORE_LAT + 8 && sb.size() != 0; i++) step();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Isolated single request: grant, inflight=1 after transfer, folded core angle
  task automatic send_one(input int idx, input logic [31:0] angle, input logic [31:0] exp_core);
    req_angle[idx*W +: W] = angle;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    check("single_ready", {60'd0, req_ready}, 64'd1 << idx);
    step();
    req_valid = '0;
    check("single_inflight", {58'd0, inflight}, 64'd1);
    step();
    check("core_angle", {32'd0, core_angle}, {32'd0, exp_core});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_angle = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_res_valid", {60'd0, res_valid}, 64'd0);
    check("rst_core_angle", {32'd0, core_angle}, 64'd0);
    check("rst_inflight", {58'd0, inflight}, 64'd0);
    check("rst_res_sin", {32'd0, res_sin}, 64'd0);
    check("rst_res_cos", {32'd0, res_cos}, 64'd0);
    req_valid = '0;
    req_angle = {32'h10000000, 32'hE0000000, 32'h50000000, 32'hA0000000};
    step();
    rst_n = 1'b1;
    step();

    // Round robin with all requesters pending
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", {60'd0, req_ready}, 64'd1 << (k % 4));
      step();
    end
    req_valid = '0;
    drain();

    send_one(0, 32'h1015BF99, 32'h1015BF99);
    drain();
    check("single_inflight_end", {58'd0, inflight}, 64'd0);

    send_one(2, 32'h6285358C, 32'hFDFD483B);
    drain();
    send_one(1, 32'h3243F6A8, 32'h3243F6A8);
    drain();
    send_one(3, 32'hCDBC0958, 32'hCDBC0958);
    drain();
    send_one(0, 32'h9B7812AF, 32'h00000000);
    drain();

    // Transfer on the same edge as a delivery
    send_one(0, 32'h01234567, 32'h01234567);
    repeat (CORE_LAT) step();
    req_angle[1*W +: W] = 32'hF0000000;
    req_valid = 4'b0010;
    step();
    check("same_cycle_inflight", {58'd0, inflight}, 64'd1);
    check("same_cycle_res", {60'd0, res_valid}, 64'd1);
    req_valid = '0;
    drain();

    // Sparse random traffic over [-PI, PI)
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 7) == 0);
        req_angle[i*W +: W] = 32'($urandom_range(0, 32'hC90FDAA1)) - PI_C;
      end
      step();
    end
    req_valid = '0;
    drain();

    // Reset with ten requests in flight
    req_valid = 4'hF;
    repeat (10) step();
    check("pre_reset_inflight", {58'd0, inflight}, 64'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {60'd0, req_ready}, 64'd0);
    check("mid_rst_res_valid", {60'd0, res_valid}, 64'd0);
    check("mid_rst_core_angle", {32'd0, core_angle}, 64'd0);
    check("mid_rst_inflight", {58'd0, inflight}, 64'd0);
    check("mid_rst_res_sin", {32'd0, res_sin}, 64'd0);
    check("mid_rst_res_cos", {32'd0, res_cos}, 64'd0);
    sb.delete();
    model_inflight = 0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (CORE_LAT + 8) step();
    check("post_rst_inflight", {58'd0, inflight}, 64'd0);
    check("post_rst_sb", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
